axis_bpr_frame_ctrl: RTL and testbench



---
 rtl/axis_bpr_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_axis_bpr_frame_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bpr_frame_ctrl.sv
// Frame geometry enforcer in front of the bad pixel replacer: pads short lines, drops long-line excess,
// frame-aligns bypass/run control. Optional error/frame counters under BPR_FRAME_CTRL_ERR_CNT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | stopped; input not accepted, no output
// ST_PASS | combinational passthrough, counting pixels/lines
// ST_PAD  | emitting PAD_VALUE until the line reaches IMG_RES_X pixels
// ST_DROP | discarding input beyond IMG_RES_X until the source tlast
module axis_bpr_frame_ctrl #(
    parameter int          IMG_RES_X = 336,
    parameter int          IMG_RES_Y = 256,
    parameter logic [15:0] PAD_VALUE = 16'h0000
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic        enable,
    input  logic        bypass_req,
    output logic        bypass_out,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        frame_active,
    output logic        frame_end,
    output logic        err_short_line,
    output logic        err_long_line
`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
    ,
    input  logic        err_cnt_clr,
    output logic [15:0] short_line_cnt,
    output logic [15:0] long_line_cnt,
    output logic [31:0] frame_cnt
`endif
);

    localparam int PW = $clog2(IMG_RES_X);
    localparam int LW = (IMG_RES_Y > 1) ? $clog2(IMG_RES_Y) : 1;
    localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_RES_X - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_RES_Y - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_PAD, ST_DROP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic          stop_pending;
    logic          last_pix, last_line;
    logic          pix_inc, line_end, start, short_ev, long_ev;

    assign last_pix     = (pix_cnt == PIX_LAST);
    assign last_line    = (line_cnt == LINE_LAST);
    assign frame_active = (state != ST_IDLE);

    always_comb begin
        state_nxt     = state;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = last_pix;
        s_axis_tready = 1'b0;
        pix_inc       = 1'b0;
        line_end      = 1'b0;
        start         = 1'b0;
        short_ev      = 1'b0;
        long_ev       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    start     = 1'b1;
                    state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready) begin
                    if (last_pix) begin
                        line_end = 1'b1;
                        if (!s_axis_tlast) begin
                            long_ev   = 1'b1;
                            state_nxt = ST_DROP;
                        end else if (last_line && !enable) begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        pix_inc = 1'b1;
                        if (s_axis_tlast) begin
                            short_ev  = 1'b1;
                            state_nxt = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                m_axis_tdata  = PAD_VALUE;
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    if (last_pix) begin
                        line_end  = 1'b1;
                        state_nxt = (last_line && !enable) ? ST_IDLE : ST_PASS;
                    end else begin
                        pix_inc = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast)
                    state_nxt = stop_pending ? ST_IDLE : ST_PASS;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state          <= ST_IDLE;
            pix_cnt        <= '0;
            line_cnt       <= '0;
            stop_pending   <= 1'b0;
            bypass_out     <= 1'b0;
            frame_end      <= 1'b0;
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
        end else begin
            state          <= state_nxt;
            frame_end      <= line_end && last_line;
            err_short_line <= short_ev;
            err_long_line  <= long_ev;
            // stop_pending only matters for the DROP exit after the final line
            if (start) begin
                bypass_out   <= bypass_req;
                stop_pending <= 1'b0;
            end
            if (pix_inc)
                pix_cnt <= pix_cnt + PW'(1);
            if (line_end) begin
                pix_cnt <= '0;
                if (last_line) begin
                    line_cnt     <= '0;
                    bypass_out   <= bypass_req;
                    stop_pending <= ~enable;
                end else begin
                    line_cnt <= line_cnt + LW'(1);
                end
            end
        end
    end

`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn || err_cnt_clr) begin
            short_line_cnt <= '0;
            long_line_cnt  <= '0;
            frame_cnt      <= '0;
        end else begin
            if (err_short_line && (short_line_cnt != '1))
                short_line_cnt <= short_line_cnt + 16'd1;
            if (err_long_line && (long_line_cnt != '1))
                long_line_cnt <= long_line_cnt + 16'd1;
            if (frame_end && (frame_cnt != '1))
                frame_cnt <= frame_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_bpr_frame_ctrl.sv
// Directed bench for axis_bpr_frame_ctrl with a 4x2 frame and PAD_VALUE 16'hFFFF.
module tb_axis_bpr_frame_ctrl;
    localparam int          X    = 4;
    localparam int          Y    = 2;
    localparam logic [15:0] PADV = 16'hFFFF;

    logic        axis_aclk = 1'b0;
    logic        axis_aresetn;
    logic        enable, bypass_req, bypass_out;
    logic [15:0] s_axis_tdata, m_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic        frame_active, frame_end, err_short_line, err_long_line;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 axis_aclk = ~axis_aclk;

    axis_bpr_frame_ctrl #(.IMG_RES_X(X), .IMG_RES_Y(Y), .PAD_VALUE(PADV)) dut (
        .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
        .enable(enable), .bypass_req(bypass_req), .bypass_out(bypass_out),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .frame_active(frame_active), .frame_end(frame_end),
        .err_short_line(err_short_line), .err_long_line(err_long_line)
    );

    task automatic cyc;
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic test_reset;
        axis_aresetn = 1'b0; enable = 1'b0; bypass_req = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        repeat (2) cyc;
        s_axis_tvalid = 1'b1;
        #1;
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready: got %b expected 0", s_axis_tready); end
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b expected 0", m_axis_tvalid); end
        n_checks++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL reset_frame_active: got %b expected 0", frame_active); end
        n_checks++; if (bypass_out !== 1'b0) begin n_fail++; $display("FAIL reset_bypass_out: got %b expected 0", bypass_out); end
        n_checks++; if ({frame_end, err_short_line, err_long_line} !== 3'b000) begin n_fail++;
            $display("FAIL reset_pulses: got %b expected 000", {frame_end, err_short_line, err_long_line}); end
        axis_aresetn = 1'b1; s_axis_tvalid = 1'b0;
        cyc;
        n_checks++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got %b expected 0", frame_active); end
    endtask

    task automatic test_normal;
        enable = 1'b1;
        cyc;
        n_checks++; if (frame_active !== 1'b1) begin n_fail++; $display("FAIL normal_start: got %b expected 1", frame_active); end
        for (int i = 0; i < 2*X; i++) begin
            s_axis_tdata = 16'h1100 + 16'(i); s_axis_tvalid = 1'b1; s_axis_tlast = (i % X == X-1);
            #1;
            n_checks++; if (m_axis_tdata !== 16'h1100 + 16'(i) || m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b1) begin n_fail++;
                $display("FAIL normal_pass beat %0d: got data %h valid %b ready %b expected data %h valid 1 ready 1",
                         i, m_axis_tdata, m_axis_tvalid, s_axis_tready, 16'h1100 + 16'(i)); end
            n_checks++; if (m_axis_tlast !== (i % X == X-1)) begin n_fail++;
                $display("FAIL normal_tlast beat %0d: got %b expected %b", i, m_axis_tlast, (i % X == X-1)); end
            cyc;
            n_checks++; if (frame_end !== (i == 2*X-1) || err_short_line !== 1'b0 || err_long_line !== 1'b0) begin n_fail++;
                $display("FAIL normal_flags beat %0d: got fe %b es %b el %b expected fe %b es 0 el 0",
                         i, frame_end, err_short_line, err_long_line, (i == 2*X-1)); end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic test_short_line;
        s_axis_tdata = 16'h00AA; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
        #1;
        n_checks++; if (m_axis_tdata !== 16'h00AA || m_axis_tlast !== 1'b0) begin n_fail++;
            $display("FAIL short_beat_a: got %h/%b expected 00aa/0", m_axis_tdata, m_axis_tlast); end
        cyc;
        s_axis_tdata = 16'h00BB; s_axis_tlast = 1'b1;
        #1;
        n_checks++; if (m_axis_tdata !== 16'h00BB || m_axis_tlast !== 1'b0) begin n_fail++;
            $display("FAIL short_beat_b: got %h/%b expected 00bb/0", m_axis_tdata, m_axis_tlast); end
        cyc;
        n_checks++; if (err_short_line !== 1'b1) begin n_fail++; $display("FAIL short_err_pulse: got %b expected 1", err_short_line); end
        s_axis_tdata = 16'h1234; s_axis_tlast = 1'b0;
        for (int j = 0; j < 2; j++) begin
            #1;
            n_checks++; if (m_axis_tdata !== PADV || m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) begin n_fail++;
                $display("FAIL short_pad %0d: got data %h valid %b ready %b expected ffff 1 0", j, m_axis_tdata, m_axis_tvalid, s_axis_tready); end
            n_checks++; if (m_axis_tlast !== (j == 1)) begin n_fail++;
                $display("FAIL short_pad_tlast %0d: got %b expected %b", j, m_axis_tlast, (j == 1)); end
            cyc;
            n_checks++; if (err_short_line !== 1'b0) begin n_fail++; $display("FAIL short_err_once %0d: got %b expected 0", j, err_short_line); end
        end
    endtask

    task automatic test_long_line;
        for (int i = 0; i < 6; i++) begin
            s_axis_tdata = 16'h2200 + 16'(i); s_axis_tvalid = 1'b1; s_axis_tlast = (i == 5);
            #1;
            if (i < X) begin
                n_checks++; if (m_axis_tdata !== 16'h2200 + 16'(i) || m_axis_tvalid !== 1'b1 || m_axis_tlast !== (i == X-1)) begin n_fail++;
                    $display("FAIL long_pass beat %0d: got %h/%b/%b expected %h/1/%b", i, m_axis_tdata, m_axis_tvalid,
                             m_axis_tlast, 16'h2200 + 16'(i), (i == X-1)); end
            end else begin
                n_checks++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin n_fail++;
                    $display("FAIL long_drop beat %0d: got valid %b ready %b expected 0 1", i, m_axis_tvalid, s_axis_tready); end
            end
            cyc;
            n_checks++; if (err_long_line !== (i == X-1) || frame_end !== (i == X-1)) begin n_fail++;
                $display("FAIL long_flags beat %0d: got el %b fe %b expected %b %b", i, err_long_line, frame_end, (i == X-1), (i == X-1)); end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        #1;
        n_checks++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || frame_active !== 1'b1) begin n_fail++;
            $display("FAIL long_resume: got valid %b ready %b active %b expected 0 1 1", m_axis_tvalid, s_axis_tready, frame_active); end
    endtask

    task automatic test_backpressure;
        int          n_xfer = 0;
        int          n_last = 0;
        logic [15:0] held_data;
        logic        held_last;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = 16'h00C0 + 16'(i); s_axis_tvalid = 1'b1; s_axis_tlast = (i == 1);
            #1;
            if (m_axis_tvalid && m_axis_tready) begin n_xfer++; if (m_axis_tlast) n_last++; end
            cyc;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        held_data = 16'h0000; held_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_axis_tready = (k % 2 == 0);
            #1;
            if (k < 3) begin
                n_checks++; if (m_axis_tdata !== PADV || m_axis_tvalid !== 1'b1) begin n_fail++;
                    $display("FAIL bp_pad k%0d: got %h/%b expected ffff/1", k, m_axis_tdata, m_axis_tvalid); end
            end
            if (k == 2) begin
                n_checks++; if (m_axis_tdata !== held_data || m_axis_tlast !== held_last) begin n_fail++;
                    $display("FAIL bp_stable: got %h/%b expected %h/%b", m_axis_tdata, m_axis_tlast, held_data, held_last); end
            end
            if (k == 3) begin
                n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_done: got valid %b expected 0", m_axis_tvalid); end
            end
            if (m_axis_tvalid && !m_axis_tready) begin held_data = m_axis_tdata; held_last = m_axis_tlast; end
            if (m_axis_tvalid && m_axis_tready) begin n_xfer++; if (m_axis_tlast) n_last++; end
            cyc;
        end
        n_checks++; if (n_xfer != X || n_last != 1) begin n_fail++;
            $display("FAIL bp_count: got %0d beats %0d tlast expected %0d beats 1 tlast", n_xfer, n_last, X); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < X; i++) begin
            s_axis_tdata = 16'h00D0 + 16'(i); s_axis_tvalid = 1'b1; s_axis_tlast = (i == X-1);
            cyc;
            n_checks++; if (frame_end !== (i == X-1)) begin n_fail++;
                $display("FAIL bp_frame_end beat %0d: got %b expected %b", i, frame_end, (i == X-1)); end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic test_frame_ctrl;
        bypass_req = 1'b1; enable = 1'b0;
        for (int i = 0; i < 2*X; i++) begin
            s_axis_tdata = 16'h3300 + 16'(i); s_axis_tvalid = 1'b1; s_axis_tlast = (i % X == X-1);
            cyc;
            n_checks++; if (bypass_out !== (i == 2*X-1) || frame_end !== (i == 2*X-1) || frame_active !== (i != 2*X-1)) begin n_fail++;
                $display("FAIL ctrl_align beat %0d: got byp %b fe %b act %b expected %b %b %b", i, bypass_out, frame_end,
                         frame_active, (i == 2*X-1), (i == 2*X-1), (i != 2*X-1)); end
        end
        s_axis_tlast = 1'b0;
        #1;
        n_checks++; if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL ctrl_idle_gate: got ready %b valid %b expected 0 0", s_axis_tready, m_axis_tvalid); end
        cyc;
        n_checks++; if (frame_active !== 1'b0 || frame_end !== 1'b0) begin n_fail++;
            $display("FAIL ctrl_idle_stay: got act %b fe %b expected 0 0", frame_active, frame_end); end
        s_axis_tvalid = 1'b0; enable = 1'b1; bypass_req = 1'b0;
        cyc;
        n_checks++; if (frame_active !== 1'b1 || bypass_out !== 1'b0) begin n_fail++;
            $display("FAIL ctrl_restart: got act %b byp %b expected 1 0", frame_active, bypass_out); end
    endtask

    task automatic test_reset_mid_line;
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = 16'h4400 + 16'(i); s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
            cyc;
        end
        axis_aresetn = 1'b0;
        cyc;
        n_checks++; if (frame_active !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || bypass_out !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_outputs: got act %b rdy %b vld %b byp %b expected 0 0 0 0", frame_active, s_axis_tready, m_axis_tvalid, bypass_out); end
        n_checks++; if ({frame_end, err_short_line, err_long_line} !== 3'b000) begin n_fail++;
            $display("FAIL rst_mid_pulses: got %b expected 000", {frame_end, err_short_line, err_long_line}); end
        axis_aresetn = 1'b1; s_axis_tvalid = 1'b0;
        cyc;
        for (int i = 0; i < X; i++) begin
            s_axis_tdata = 16'h5500 + 16'(i); s_axis_tvalid = 1'b1; s_axis_tlast = (i == X-1);
            #1;
            n_checks++; if (m_axis_tdata !== 16'h5500 + 16'(i) || m_axis_tvalid !== 1'b1 || m_axis_tlast !== (i == X-1)) begin n_fail++;
                $display("FAIL rst_clean beat %0d: got %h/%b/%b expected %h/1/%b", i, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
                         16'h5500 + 16'(i), (i == X-1)); end
            cyc;
            n_checks++; if (err_short_line !== 1'b0 || err_long_line !== 1'b0) begin n_fail++;
                $display("FAIL rst_clean_err beat %0d: got es %b el %b expected 0 0", i, err_short_line, err_long_line); end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    initial begin
        test_reset;
        test_normal;
        test_short_line;
        test_long_line;
        test_backpressure;
        test_frame_ctrl;
        test_reset_mid_line;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
